// File: rtl/t02_ram_pkg.sv
// Shared types and constants for the t02 RAM responder.
//   state_t  : responder FSM states (IDLE / ACCESS / DONE)
//   op_t     : latched operation (OP_READ / OP_WRITE)
//   DEFAULT_OOR_DATA, MAX_LATENCY, CNT_W : defaults and counter sizing
//   addr_oor : true when any byte-address bit above the word index is set
package t02_ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [31:0] DEFAULT_OOR_DATA = 32'hBAD0_BAD0;
  localparam int unsigned MAX_LATENCY      = 15;
  localparam int unsigned CNT_W            = $clog2(MAX_LATENCY + 1);

  // aw = log2(depth in words); bits [aw+1:2] form the word index.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
    return |(addr >> (aw + 2));
  endfunction

endpackage

// File: rtl/t02_ram_array.sv
// Single-port WORDS x 32 storage for the RAM responder.
//   clk   : write clock
//   we    : write enable, commits wdata at addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : asynchronous read of the word at addr; the responder registers it
// Contents are not reset.
module t02_ram_array #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/t02_ram_responder.sv
// Memory-side responder for the CPU RAM request bus. Accepts one read or
// write at a time, services it from an internal word array after LATENCY
// ACCESS cycles, and signals completion by dropping busy_o.
//   clk, nrst : clock, asynchronous active-low reset
//   ramaddr   : byte address (bits [1:0] ignored)
//   ramstore  : write data
//   Ren, Wen  : read / write request (Wen wins when both are high)
//   ramload   : registered read data, held until the next read completes
//   busy_o    : high from the request cycle through the last ACCESS cycle
//   err_o     : only when T02_RAM_ERR_EN is defined; high in the DONE cycle
//               of an out-of-range or misaligned request
module t02_ram_responder
  import t02_ram_pkg::*;
#(
  parameter int unsigned WORDS    = 256,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] OOR_DATA = DEFAULT_OOR_DATA
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        Ren,
  input  logic        Wen,
  output logic [31:0] ramload,
  output logic        busy_o
`ifdef T02_RAM_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned    AW       = $clog2(WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           state;
  op_t              op_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      data_q;
  logic             oor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic             req;
  logic             req_oor;
  logic             access_last;
  logic             arr_we;
  logic [31:0]      arr_rdata;

  assign req         = Ren | Wen;
  assign req_oor     = addr_oor(ramaddr, AW);
  assign access_last = (state == ACCESS) && (cnt_q == '0);
  // Out-of-range writes are dropped: the aliased in-range word must not change.
  assign arr_we      = access_last && (op_q == OP_WRITE) && !oor_q;

  // In IDLE busy follows the request lines so the requester sees it in the
  // request cycle; afterwards it comes from the registered copy.
  assign busy_o = (state == IDLE) ? req : busy_q;

  t02_ram_array #(
    .WORDS(WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (idx_q),
    .wdata(data_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      op_q    <= OP_READ;
      idx_q   <= '0;
      data_q  <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ramload <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q  <= ramaddr[AW+1:2];
            data_q <= ramstore;
            oor_q  <= req_oor;
            op_q   <= Wen ? OP_WRITE : OP_READ;
            cnt_q  <= CNT_INIT;
            busy_q <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (op_q == OP_READ) begin
              ramload <= oor_q ? OOR_DATA : arr_rdata;
            end
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // Request lines are ignored here: one-cycle recovery.
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef T02_RAM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if ((state == IDLE) && req) begin
        err_q <= req_oor | (|ramaddr[1:0]);
      end
      err_o <= access_last && err_q;
    end
  end
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^ramaddr[1:0];
`endif

endmodule

// File: tb/tb_t02_ram_responder.sv
module tb_t02_ram_responder;

  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 1;
  localparam logic [31:0] OOR  = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] ramaddr_v  [2];
  logic [31:0] ramstore_v [2];
  logic [31:0] ramload_v  [2];
  logic        Ren_v      [2];
  logic        Wen_v      [2];
  logic        busy_v     [2];
`ifdef T02_RAM_ERR_EN
  logic        err_v      [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb [$];

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt [$];

  logic [31:0] ha [3];
  logic [31:0] hd [3];

  t02_ram_responder #(
    .WORDS(256), .LATENCY(LAT0), .OOR_DATA(OOR)
  ) dut (
    .clk(clk), .nrst(nrst), .ramaddr(ramaddr_v[0]), .ramstore(ramstore_v[0]),
    .Ren(Ren_v[0]), .Wen(Wen_v[0]), .ramload(ramload_v[0]), .busy_o(busy_v[0])
`ifdef T02_RAM_ERR_EN
    , .err_o(err_v[0])
`endif
  );

  t02_ram_responder #(
    .WORDS(256), .LATENCY(LAT1), .OOR_DATA(OOR)
  ) dut1 (
    .clk(clk), .nrst(nrst), .ramaddr(ramaddr_v[1]), .ramstore(ramstore_v[1]),
    .Ren(Ren_v[1]), .Wen(Wen_v[1]), .ramload(ramload_v[1]), .busy_o(busy_v[1])
`ifdef T02_RAM_ERR_EN
    , .err_o(err_v[1])
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input string name);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d; v.exp = exp; v.name = name;
    vt.push_back(v);
  endtask

  // One complete request: drive in IDLE, count busy cycles, compare ramload
  // in the first busy_o=0 cycle. Request lines and address are scrambled
  // during ACCESS to show only the latched copies are used.
  task automatic access(input int s, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string name);
    int unsigned nb;
    int unsigned lat;
    logic [31:0] e;
    lat = (s == 0) ? LAT0 : LAT1;
    sb.push_back(exp);
    @(negedge clk);
    Wen_v[s] = w; Ren_v[s] = r; ramaddr_v[s] = a; ramstore_v[s] = d;
    #1;
    nb = busy_v[s] ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      Wen_v[s] = 1'b0; Ren_v[s] = 1'b0;
      ramaddr_v[s] = $urandom; ramstore_v[s] = $urandom;
      #1;
      if (!busy_v[s]) break;
      nb++;
    end
    chk({name, "_busy_cycles"}, 32'(nb), 32'(lat + 1));
    e = sb.pop_front();
    chk({name, "_ramload"}, ramload_v[s], e);
`ifdef T02_RAM_ERR_EN
    chk({name, "_err"}, {31'b0, err_v[s]}, {31'b0, (|a[31:10]) | (|a[1:0])});
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      ramaddr_v[i] = '0; ramstore_v[i] = '0; Ren_v[i] = 1'b0; Wen_v[i] = 1'b0;
    end
    nrst = 1'b0;

    //        w     r     addr           wdata          expected ramload
    add_vec(1'b1, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, "wr00");
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, "wr10");
    add_vec(1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "rd10");
    add_vec(1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'hDEAD_BEEF, "dual20");
    add_vec(1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_1234, "rd20");
    add_vec(1'b1, 1'b0, 32'h0000_03FC, 32'hA5A5_0001, 32'h0000_1234, "wr_last");
    add_vec(1'b0, 1'b1, 32'h0000_03FC, 32'h0,         32'hA5A5_0001, "rd_last");
    add_vec(1'b0, 1'b1, 32'h0000_0400, 32'h0,         OOR,           "rd_oor");
    add_vec(1'b1, 1'b0, 32'h0000_0400, 32'h5555_5555, OOR,           "wr_oor");
    add_vec(1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h1111_1111, "rd00_alias");
    add_vec(1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "rd10_again");
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'hDEAD_BEEF, "wr10_cafe");
    add_vec(1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'hCAFE_F00D, "rd13_misal");
    add_vec(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         OOR,           "rd_oor_top");
    add_vec(1'b0, 1'b1, 32'h8000_0010, 32'h0,         OOR,           "rd_oor_msb");

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy0", {31'b0, busy_v[0]}, 32'h0);
    chk("reset_ramload0", ramload_v[0], 32'h0);
    chk("reset_busy1", {31'b0, busy_v[1]}, 32'h0);
`ifdef T02_RAM_ERR_EN
    chk("reset_err0", {31'b0, err_v[0]}, 32'h0);
`endif
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      access(0, vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].exp, vt[i].name);
    end

    // Reset in the middle of a write: word 5 holds 0, write 0x77 is aborted.
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, OOR, "wr5_zero");
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 32'hCAFE_F00D, "rd10_pre_rst");
    @(negedge clk);
    Wen_v[0] = 1'b1; ramaddr_v[0] = 32'h14; ramstore_v[0] = 32'h77;
    #1;
    chk("rst_req_busy", {31'b0, busy_v[0]}, 32'h1);
    @(negedge clk);
    Wen_v[0] = 1'b0;
    #1;
    chk("rst_access_busy", {31'b0, busy_v[0]}, 32'h1);
    nrst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy_v[0]}, 32'h0);
    chk("rst_mid_ramload", ramload_v[0], 32'h0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    access(0, 1'b0, 1'b1, 32'h14, 32'h0, 32'h0, "rd5_after_rst");

    // Held Ren on the LATENCY=1 instance: three back-to-back reads.
    ha[0] = 32'h4;         ha[1] = 32'h8;         ha[2] = 32'hC;
    hd[0] = 32'h1000_0001; hd[1] = 32'h1000_0002; hd[2] = 32'h1000_0003;
    for (int k = 0; k < 3; k++) begin
      access(1, 1'b1, 1'b0, ha[k], hd[k], 32'h0, "d1_wr");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      Ren_v[1] = 1'b1; ramaddr_v[1] = ha[k];
      sb.push_back(hd[k]);
      #1;
      chk("held_req_busy", {31'b0, busy_v[1]}, 32'h1);
      @(negedge clk);
      ramaddr_v[1] = ha[(k + 1) % 3];
      #1;
      chk("held_access_busy", {31'b0, busy_v[1]}, 32'h1);
      @(negedge clk);
      #1;
      chk("held_done_busy", {31'b0, busy_v[1]}, 32'h0);
      chk("held_ramload", ramload_v[1], sb.pop_front());
    end
    @(negedge clk);
    Ren_v[1] = 1'b0;
    #1;
    chk("held_release_busy", {31'b0, busy_v[1]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
